dm_sized: RTL

- Parametrised data memory for the multicycle CPU; successor to the fixed 32-word/word-only data memory.
- Adds byte/half/word loads and stores, sign/zero extension, and misalignment detection.
- Uses a req/ready/dvalid handshake with configurable access latency and fully synchronous writes.
- Sits between the datapath's MEM stage and the controller, which stalls on ready/dvalid.

---
 rtl/dm_sized.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dm_sized.sv
// Sized data memory for the multicycle CPU: byte/half/word loads and stores with
// sign/zero extension, misalignment flagging, and a req/ready/dvalid handshake.
module dm_sized #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [1:0]  size_i,
   input  logic        sext_i,
   input  logic [31:0] din_i,
   output logic        ready_o,
   output logic        dvalid_o,
   output logic [31:0] dout_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, sext_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [1:0]          size_q;
   logic [31:0]         din_q;
   logic [31:0]         dout_q, dout_d;
   logic                mis_q, mis_d;
   logic [31:0]         mem_q [2**ADDR_W];

   logic                accept, access;
   logic                a_we, a_sext;
   logic [ADDR_W+1:0]   a_addr;
   logic [1:0]          a_size;
   logic [31:0]         a_din;
   logic [ADDR_W-1:0]   word_idx;
   logic [1:0]          off;
   logic [31:0]         rd_word, shifted, ld_data, wdata;
   logic [3:0]          be;
   logic                mis;
   logic                unused_addr;

   assign unused_addr = ^addr_i[31:ADDR_W+2];

   assign ready_o    = (state_q != S_WAIT);
   assign dvalid_o   = (state_q == S_RESP);
   assign dout_o     = dout_q;
   assign misalign_o = mis_q;
   assign accept     = req_i & ready_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      if (state_q == S_WAIT) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            access  = 1'b1;
         end
      end else if (accept) begin
         if (LATENCY == 1) begin
            state_d = S_RESP;
            access  = 1'b1;
         end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
         end
      end else begin
         state_d = S_IDLE;
      end
   end

   // With single-cycle latency the access happens on the accept edge itself,
   // so the live request is used instead of the captured copy.
   assign a_we   = (LATENCY == 1) ? we_i                 : we_q;
   assign a_addr = (LATENCY == 1) ? addr_i[ADDR_W+1:0]   : addr_q;
   assign a_size = (LATENCY == 1) ? size_i               : size_q;
   assign a_sext = (LATENCY == 1) ? sext_i               : sext_q;
   assign a_din  = (LATENCY == 1) ? din_i                : din_q;

   assign word_idx = a_addr[ADDR_W+1:2];
   assign off      = a_addr[1:0];
   assign rd_word  = mem_q[word_idx];
   assign shifted  = rd_word >> {off, 3'b000};
   assign mis      = ((a_size == 2'b01) && off[0]) || (a_size[1] && (off != 2'b00));

   always_comb begin
      be      = 4'hF;
      wdata   = a_din;
      ld_data = rd_word;
      case (a_size)
         2'b00: begin
            be      = 4'b0001 << off;
            wdata   = {4{a_din[7:0]}};
            ld_data = {{24{a_sext & shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            be      = off[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{a_din[15:0]}};
            ld_data = {{16{a_sext & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            be      = 4'hF;
            wdata   = a_din;
            ld_data = rd_word;
         end
      endcase
   end

   always_comb begin
      dout_d = dout_q;
      mis_d  = 1'b0;
      if (access) begin
         mis_d  = mis;
         dout_d = (mis || a_we) ? 32'd0 : ld_data;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         dout_q  <= 32'd0;
         mis_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         din_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         mis_q   <= mis_d;
         if (accept) begin
            we_q   <= we_i;
            addr_q <= addr_i[ADDR_W+1:0];
            size_q <= size_i;
            sext_q <= sext_i;
            din_q  <= din_i;
         end
      end
   end

   // Array has no reset; rst_i gating keeps a reset edge from committing a store.
   always_ff @(posedge clk_i) begin
      if (access && a_we && !mis && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule
